// File: rtl/fetch_redirect_if.sv
// Instruction-memory fetch bus between the IF sequencer and imem.
// One request outstanding at most; responses arrive one or more cycles later.
interface fetch_redirect_if;
  logic        req;
  logic [31:0] addr;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/fetch_redirect_unit.sv
// IF-stage PC sequencer with MEM-stage branch redirect and IF/ID register.
// Define FETCH_STATS_EN to add redirect_cnt/drop_cnt statistics outputs.
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch_taken_mem,
  input  logic [31:0] branch_target_mem,
  input  logic        stall_if,
  fetch_redirect_if.master imem,
  output logic [31:0] pc_if,
  output logic [31:0] instr_if,
  output logic        instr_valid_if,
  output logic        flush_o
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] redirect_cnt,
  output logic [15:0] drop_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, HOLD, DROP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] skid_q, skid_d;
  logic        skid_vld_q, skid_vld_d;
  logic        load;
  logic [31:0] ld_data;
  logic        resp_live;

  assign imem.req  = (state_q == ISSUE);
  assign imem.addr = pc_q;
  assign ld_data   = (state_q == HOLD) ? skid_q : imem.rdata;
  // a response can only be pending in WAIT or DROP
  assign resp_live = (state_q == WAIT) || (state_q == DROP);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    load       = 1'b0;
    unique case (state_q)
      IDLE:  state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (imem.rvalid && stall_if) begin
          skid_d     = imem.rdata;
          skid_vld_d = 1'b1;
          state_d    = HOLD;
        end else if (imem.rvalid) begin
          load    = 1'b1;
          pc_d    = pc_q + 32'd4;
          state_d = ISSUE;
        end
      end
      HOLD: begin
        if (!stall_if && skid_vld_q) begin
          load       = 1'b1;
          skid_vld_d = 1'b0;
          pc_d       = pc_q + 32'd4;
          state_d    = ISSUE;
        end
      end
      DROP: if (imem.rvalid) state_d = ISSUE;
      default: state_d = IDLE;
    endcase
    // redirect overrides everything; a request still in flight must be dropped
    if (branch_taken_mem) begin
      load       = 1'b0;
      skid_vld_d = 1'b0;
      pc_d       = branch_target_mem & ~32'h3;
      if ((state_q == ISSUE) || (resp_live && !imem.rvalid))
        state_d = DROP;
      else
        state_d = ISSUE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      pc_q           <= RESET_PC;
      skid_q         <= '0;
      skid_vld_q     <= 1'b0;
      pc_if          <= '0;
      instr_if       <= NOP_INSTR;
      instr_valid_if <= 1'b0;
      flush_o        <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      flush_o    <= branch_taken_mem;
      if (branch_taken_mem) begin
        instr_valid_if <= 1'b0;
        instr_if       <= NOP_INSTR;
      end else if (load) begin
        instr_if       <= ld_data;
        pc_if          <= pc_q;
        instr_valid_if <= 1'b1;
      end
    end
  end

`ifdef FETCH_STATS_EN
  logic drop;
  assign drop = imem.rvalid &&
                ((state_q == DROP) ||
                 ((state_q == WAIT) && branch_taken_mem));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_cnt <= '0;
      drop_cnt     <= '0;
    end else begin
      if (branch_taken_mem && (redirect_cnt != '1))
        redirect_cnt <= redirect_cnt + 32'd1;
      if (drop && (drop_cnt != '1))
        drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Bench for fetch_redirect_unit: random-latency memory plus a
// transaction-level model of which fetched words must reach IF/ID.
module tb_fetch_redirect_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        br = 1'b0;
  logic [31:0] tgt = '0;
  logic        stall = 1'b0;
  logic [31:0] pc_if, instr_if;
  logic        instr_valid_if, flush_o;
`ifdef FETCH_STATS_EN
  logic [31:0] redirect_cnt;
  logic [15:0] drop_cnt;
`endif

  fetch_redirect_if bus ();

  fetch_redirect_unit dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .branch_taken_mem  (br),
    .branch_target_mem (tgt),
    .stall_if          (stall),
    .imem              (bus),
    .pc_if             (pc_if),
    .instr_if          (instr_if),
    .instr_valid_if    (instr_valid_if),
    .flush_o           (flush_o)
`ifdef FETCH_STATS_EN
    ,
    .redirect_cnt      (redirect_cnt),
    .drop_cnt          (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model: what is in flight, what is parked, what IF/ID must show
  bit          m_idle, m_out, m_stale, m_buf, m_valid, m_flush;
  logic [31:0] m_out_addr, m_buf_addr, m_buf_data;
  logic [31:0] m_instr, m_pc, m_fetch;
  int          m_redirects, m_drops;

  // memory
  bit          mem_pend;
  int          mem_due;
  logic [31:0] mem_addr;
  int          lat_lo = 1;
  int          lat_hi = 1;
  int          edge_n = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idle = 1; m_out = 0; m_stale = 0; m_buf = 0;
    m_valid = 0; m_flush = 0;
    m_instr = NOP; m_pc = '0; m_fetch = '0;
    m_redirects = 0; m_drops = 0;
    mem_pend = 0;
  endtask

  task automatic deliver(input logic [31:0] a, input logic [31:0] d);
    m_valid = 1; m_instr = d; m_pc = a; m_fetch = a + 32'd4;
  endtask

  task automatic check_all();
    logic er;
    er = !m_idle && !m_out && !m_buf;
    chk("imem_req", {31'b0, bus.req}, {31'b0, er});
    if (er) chk("imem_addr", bus.addr, m_fetch);
    chk("instr_valid", {31'b0, instr_valid_if}, {31'b0, m_valid});
    chk("instr_if", instr_if, m_instr);
    chk("pc_if", pc_if, m_pc);
    chk("flush_o", {31'b0, flush_o}, {31'b0, m_flush});
`ifdef FETCH_STATS_EN
    chk("redirect_cnt", redirect_cnt, m_redirects);
    chk("drop_cnt", {16'b0, drop_cnt}, m_drops);
`endif
  endtask

  // one clock: drive at negedge, update model at posedge, check at negedge
  task automatic step(input bit b, input logic [31:0] t, input bit s);
    bit rv, rq, got, gs;
    logic [31:0] ra, rd, ga;
    rv = mem_pend && (mem_due == edge_n + 1);
    rd = rv ? mem_word(mem_addr) : $urandom;
    br = b; tgt = t; stall = s;
    bus.rvalid = rv; bus.rdata = rd;
    rq = bus.req; ra = bus.addr;
    @(posedge clk);
    edge_n++;
    if (rv) mem_pend = 0;
    if (rq) begin
      mem_pend = 1;
      mem_due  = edge_n + int'($urandom_range(lat_hi, lat_lo));
      mem_addr = ra;
    end
    m_flush = b;
    m_idle  = 0;
    got = rv && m_out;
    ga  = m_out_addr;
    gs  = m_stale;
    if (got) m_out = 0;
    if (b) begin
      m_redirects++;
      m_valid = 0; m_instr = NOP; m_buf = 0;
      m_fetch = t & ~32'h3;
      if (got) m_drops++;
      if (m_out) m_stale = 1;
      if (rq) begin m_out = 1; m_stale = 1; m_out_addr = ra; end
    end else begin
      if (rq) begin m_out = 1; m_stale = 0; m_out_addr = ra; end
      if (got) begin
        if (gs) m_drops++;
        else if (s) begin m_buf = 1; m_buf_addr = ga; m_buf_data = rd; end
        else deliver(ga, rd);
      end else if (m_buf && !s) begin
        m_buf = 0;
        deliver(m_buf_addr, m_buf_data);
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n, input bit s);
    repeat (n) step(1'b0, '0, s);
  endtask

  function automatic bit in_wait();
    return m_out && !m_stale && !(mem_pend && mem_due == edge_n + 1);
  endfunction

  function automatic bit rv_next_live();
    return m_out && !m_stale && mem_pend && (mem_due == edge_n + 1);
  endfunction

  initial begin
    bit found;
    bus.rvalid = 1'b0;
    bus.rdata  = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // sequential fetch, latency 1
    lat_lo = 1; lat_hi = 1;
    run(8, 1'b0);

    // stall across a response arrival
    run(1, 1'b0);
    run(5, 1'b1);
    run(6, 1'b0);

    // redirect while waiting on memory
    lat_lo = 3; lat_hi = 3;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (in_wait()) found = 1;
      else step(1'b0, '0, 1'b0);
    end
    chk("reach_wait", {31'b0, found}, 32'd1);
    step(1'b1, 32'h0000_0103, 1'b0);
    run(10, 1'b0);

    // redirect on the same edge as the response
    lat_lo = 2; lat_hi = 2;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (rv_next_live()) found = 1;
      else step(1'b0, '0, 1'b0);
    end
    chk("reach_rvalid", {31'b0, found}, 32'd1);
    step(1'b1, 32'h0000_2000, 1'b0);
    run(8, 1'b0);

    // address wrap, back-to-back redirects, redirect under stall
    lat_lo = 1; lat_hi = 1;
    step(1'b1, 32'h0000_0500, 1'b0);
    step(1'b1, 32'hFFFF_FFFE, 1'b0);
    run(8, 1'b0);
    run(1, 1'b1);
    step(1'b1, 32'h0000_0040, 1'b1);
    run(3, 1'b1);
    run(6, 1'b0);

    // randomized traffic
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) == 0, $urandom,
           $urandom_range(0, 2) == 0);

    // asynchronous reset in the middle of a fetch
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (in_wait()) found = 1;
      else step(1'b0, '0, 1'b0);
    end
    chk("reach_wait2", {31'b0, found}, 32'd1);
    br = 1'b0; stall = 1'b0; bus.rvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lat_lo = 1; lat_hi = 2;
    run(6, 1'b0);
    step(1'b1, 32'h0000_0800, 1'b0);
    run(8, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
